// File: rtl/jt12_timer_pkg.sv
// Shared constants for the OPN Timer A / Timer B block: counter widths,
// default prescale ratios and the register 0x27 bit layout.
package jt12_timer_pkg;

  localparam int TA_W      = 10;
  localparam int TB_W      = 8;
  localparam int PRE_A_DEF = 24;
  localparam int PRE_B_DEF = 16;

  localparam int R27_LOAD_A  = 0;
  localparam int R27_LOAD_B  = 1;
  localparam int R27_EN_A    = 2;
  localparam int R27_EN_B    = 3;
  localparam int R27_CLR_A   = 4;
  localparam int R27_CLR_B   = 5;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One programmable up-counter with reload on overflow, load-edge start,
// status flag and a single-cycle overflow pulse.
module jt12_timer_cnt
  import jt12_timer_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] value,
  input  logic          en_irq,
  input  logic          clr_flag,
  output logic          flag,
  output logic          overflow
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  cnt_state_e    state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          load_r;
  logic          load_rise_s;
  logic          ovf_s;

  // next-state, count and overflow condition
  always_comb begin
    load_rise_s = load & ~load_r;
    state_nx    = state;
    count_nx    = count;
    ovf_s       = 1'b0;
    if (load_rise_s) begin
      state_nx = CNT_RUN;
      count_nx = value;
    end else begin
      case (state)
        CNT_RUN: begin
          if (!load) begin
            state_nx = CNT_IDLE;
          end else if (tick) begin
            if (count == CNT_MAX) begin
              count_nx = value;
              ovf_s    = 1'b1;
            end else begin
              count_nx = count + CNT_ONE;
            end
          end else begin
            count_nx = count;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  // state, count, flag and overflow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CNT_IDLE;
      count    <= '0;
      // a load held high through reset must not look like a fresh edge
      load_r   <= 1'b1;
      flag     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      load_r   <= load;
      overflow <= ovf_s;
      if (ovf_s && en_irq) begin
        flag <= 1'b1;
      end else if (clr_flag) begin
        flag <= 1'b0;
      end else begin
        flag <= flag;
      end
    end
  end

endmodule

// File: rtl/jt12_timer_ab.sv
// YM2612/YM2203 Timer A / Timer B: clk_en prescalers, two reloadable
// counters and the registered active-low interrupt line.
module jt12_timer_ab
  import jt12_timer_pkg::*;
#(
  parameter int PRE_A = PRE_A_DEF,
  parameter int PRE_B = PRE_B_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [TA_W-1:0] value_A,
  input  logic [TB_W-1:0] value_B,
  input  logic            load_A,
  input  logic            load_B,
  input  logic            en_irq_A,
  input  logic            en_irq_B,
  input  logic            clr_flag_A,
  input  logic            clr_flag_B,
  output logic            flag_A,
  output logic            flag_B,
  output logic            overflow_A,
  output logic            irq_n
);

  localparam logic [4:0] PRE_A_LAST = 5'(PRE_A - 1);
  localparam logic [3:0] PRE_B_LAST = 4'(PRE_B - 1);

  logic [4:0] pre_a;
  logic [3:0] pre_b;
  logic       tick_a;
  logic       tick_b;
  logic       overflow_b_unused;

  assign tick_a = clk_en & (pre_a == PRE_A_LAST);
  assign tick_b = tick_a & (pre_b == PRE_B_LAST);

  // free-running prescalers and the interrupt register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_a <= 5'd0;
      pre_b <= 4'd0;
      irq_n <= 1'b1;
    end else begin
      if (clk_en) begin
        pre_a <= tick_a ? 5'd0 : pre_a + 5'd1;
      end else begin
        pre_a <= pre_a;
      end
      if (tick_a) begin
        pre_b <= tick_b ? 4'd0 : pre_b + 4'd1;
      end else begin
        pre_b <= pre_b;
      end
      irq_n <= ~(flag_A | flag_B);
    end
  end

  jt12_timer_cnt #(.CW(TA_W)) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick_a),
    .load     (load_A),
    .value    (value_A),
    .en_irq   (en_irq_A),
    .clr_flag (clr_flag_A),
    .flag     (flag_A),
    .overflow (overflow_A)
  );

  // Timer B overflow has no consumer outside the flag
  jt12_timer_cnt #(.CW(TB_W)) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick_b),
    .load     (load_B),
    .value    (value_B),
    .en_irq   (en_irq_B),
    .clr_flag (clr_flag_B),
    .flag     (flag_B),
    .overflow (overflow_b_unused)
  );

endmodule

// File: tb/tb_jt12_timer_ab.sv
// Directed bench for jt12_timer_ab: an event-count model of the timers is
// compared with the DUT after every clock, plus hand-computed pins.
module tb_jt12_timer_ab;

  localparam int PA = 24;
  localparam int PB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic [9:0] value_A = 10'd0;
  logic [7:0] value_B = 8'd0;
  logic       load_A = 1'b0, load_B = 1'b0;
  logic       en_irq_A = 1'b0, en_irq_B = 1'b0;
  logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
  logic       flag_A, flag_B, overflow_A, irq_n;

  int checks = 0;
  int errors = 0;

  // model state: clk_en events since reset, plus per-timer run/count/flag
  int m_ce = 0, n_ce;
  bit m_run_a, m_run_b, m_lp_a = 1'b1, m_lp_b = 1'b1;
  int m_cnt_a, m_cnt_b;
  bit m_flag_a, m_flag_b, m_ovf_a, m_ovf_b, m_irq_n = 1'b1, m_tick_a;
  bit n_run_a, n_run_b, n_lp_a, n_lp_b, n_flag_a, n_flag_b;
  bit n_ovf_a, n_ovf_b, n_irq_n, n_tick_a, n_tick_b;
  int n_cnt_a, n_cnt_b;

  int ce_phase = 0;
  int pulses, pulses_b, ticks;

  always #5 clk = ~clk;

  jt12_timer_ab dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B),
    .en_irq_A(en_irq_A), .en_irq_B(en_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .flag_A(flag_A), .flag_B(flag_B),
    .overflow_A(overflow_A), .irq_n(irq_n)
  );

  task automatic expect_v(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timer_next(input bit tick, input bit ld, input bit lp, input bit run,
                            input int cnt, input int val, input int maxv, input bit en,
                            input bit clr, input bit flg, output bit nrun, output int ncnt,
                            output bit novf, output bit nflg);
    nrun = run;
    ncnt = cnt;
    novf = 1'b0;
    if (ld && !lp) begin
      nrun = 1'b1;
      ncnt = val;
    end else if (!ld) begin
      nrun = 1'b0;
    end else if (run && tick) begin
      if (cnt == maxv) begin
        ncnt = val;
        novf = 1'b1;
      end else begin
        ncnt = cnt + 1;
      end
    end
    nflg = (novf && en) ? 1'b1 : (clr ? 1'b0 : flg);
  endtask

  task automatic model_eval();
    n_tick_a = clk_en && (((m_ce + 1) % PA) == 0);
    n_tick_b = clk_en && (((m_ce + 1) % (PA * PB)) == 0);
    timer_next(n_tick_a, load_A, m_lp_a, m_run_a, m_cnt_a, int'(value_A), 1023,
               en_irq_A, clr_flag_A, m_flag_a, n_run_a, n_cnt_a, n_ovf_a, n_flag_a);
    timer_next(n_tick_b, load_B, m_lp_b, m_run_b, m_cnt_b, int'(value_B), 255,
               en_irq_B, clr_flag_B, m_flag_b, n_run_b, n_cnt_b, n_ovf_b, n_flag_b);
    n_irq_n = !(m_flag_a || m_flag_b);
    n_ce    = m_ce + (clk_en ? 1 : 0);
    n_lp_a  = load_A;
    n_lp_b  = load_B;
    if (!rst_n) begin
      n_ce = 0; n_run_a = 0; n_run_b = 0; n_cnt_a = 0; n_cnt_b = 0;
      n_flag_a = 0; n_flag_b = 0; n_ovf_a = 0; n_ovf_b = 0; n_irq_n = 1;
      n_lp_a = 1; n_lp_b = 1; n_tick_a = 0;
    end
  endtask

  // the single per-cycle compare point: advance model, clock DUT, compare
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    m_ce = n_ce; m_run_a = n_run_a; m_run_b = n_run_b; m_lp_a = n_lp_a; m_lp_b = n_lp_b;
    m_cnt_a = n_cnt_a; m_cnt_b = n_cnt_b; m_flag_a = n_flag_a; m_flag_b = n_flag_b;
    m_ovf_a = n_ovf_a; m_ovf_b = n_ovf_b; m_irq_n = n_irq_n; m_tick_a = n_tick_a;
    expect_v("flag_A", int'(flag_A), int'(m_flag_a));
    expect_v("flag_B", int'(flag_B), int'(m_flag_b));
    expect_v("overflow_A", int'(overflow_A), int'(m_ovf_a));
    expect_v("irq_n", int'(irq_n), int'(m_irq_n));
  endtask

  task automatic run(input int n, input int period, input bit stop);
    pulses = 0; pulses_b = 0; ticks = 0;
    for (int i = 0; i < n; i++) begin
      clk_en = (period > 0) && ((ce_phase % period) == 0);
      ce_phase++;
      step();
      if (m_ovf_a) pulses++;
      if (m_ovf_b) pulses_b++;
      if (m_tick_a) ticks++;
      if (stop && m_ovf_a) break;
    end
  endtask

  initial begin
    int tk;
    bit hit;

    // reset, with clk_en high to show it does not matter
    rst_n = 1'b0; clk_en = 1'b1;
    step(); step();
    rst_n = 1'b1; clk_en = 1'b0;
    step();
    expect_v("rst_flag_A", int'(flag_A), 0);
    expect_v("rst_flag_B", int'(flag_B), 0);
    expect_v("rst_ovf_A", int'(overflow_A), 0);
    expect_v("rst_irq_n", int'(irq_n), 1);

    // Timer B at max without flag enable: two overflows in 768 clk_en
    value_B = 8'd255; load_B = 1'b1; ce_phase = 0;
    run(768, 1, 1'b0);
    expect_v("b_ovf_count", pulses_b, 2);
    expect_v("b_flag_quiet", int'(flag_B), 0);
    expect_v("b_irq_quiet", int'(irq_n), 1);

    // Timer A from 1022, clk_en every 6 clk: overflow on 2nd tick
    value_A = 10'd1022; en_irq_A = 1'b1; load_A = 1'b1; ce_phase = 0;
    run(300, 6, 1'b1);
    expect_v("a_first_ovf", pulses, 1);
    expect_v("a_ticks_to_ovf", ticks, 2);
    expect_v("a_flag_set", int'(flag_A), 1);
    expect_v("a_irq_lag", int'(irq_n), 1);
    expect_v("a_reload", m_cnt_a, 1022);
    run(1, 6, 1'b0);
    expect_v("a_irq_low", int'(irq_n), 0);

    // clear in the same cycle as the next overflow: set wins
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      clk_en = (ce_phase % 6) == 0;
      ce_phase++;
      model_eval();
      clr_flag_A = n_ovf_a;
      hit = n_ovf_a;
      step();
      clr_flag_A = 1'b0;
    end
    expect_v("clr_collide_hit", int'(hit), 1);
    expect_v("clr_collide_flag", int'(flag_A), 1);
    clr_flag_A = 1'b1; clk_en = 1'b0;
    step();
    clr_flag_A = 1'b0;
    expect_v("clr_alone_flag", int'(flag_A), 0);
    step();
    expect_v("clr_alone_irq", int'(irq_n), 1);

    // hold at 1020 for 100 ticks, then restart from 0
    load_A = 1'b0; step();
    value_A = 10'd1018; load_A = 1'b1; step();
    tk = 0;
    for (int i = 0; i < 100 && tk < 2; i++) begin
      run(1, 1, 1'b0);
      tk += ticks;
    end
    expect_v("hold_reach", m_cnt_a, 1020);
    load_A = 1'b0;
    run(PA * 100, 1, 1'b0);
    expect_v("hold_no_ovf", pulses, 0);
    expect_v("hold_frozen", m_cnt_a, 1020);
    value_A = 10'd0; load_A = 1'b1;
    step();
    expect_v("restart_zero", m_cnt_a, 0);
    run(1023 * PA, 1, 1'b0);
    expect_v("restart_early", pulses, 0);
    run(PA + 1, 1, 1'b1);
    expect_v("restart_1024", pulses, 1);

    // clk_en held low: nothing moves, but a load edge still loads
    run(1000, 0, 1'b0);
    expect_v("ce_hold_no_ovf", pulses, 0);
    load_A = 1'b0; step();
    value_A = 10'd1023; load_A = 1'b1; step();
    expect_v("ce_hold_load", m_cnt_a, 1023);
    run(PA + 1, 1, 1'b1);
    expect_v("ce_resume_ovf", pulses, 1);
    expect_v("ce_resume_flag", int'(flag_A), 1);

    // mid-count reset with flag set and load held high
    run(3, 1, 1'b0);
    rst_n = 1'b0; clk_en = 1'b1;
    step();
    rst_n = 1'b1;
    expect_v("mid_rst_flag_A", int'(flag_A), 0);
    expect_v("mid_rst_irq_n", int'(irq_n), 1);
    expect_v("mid_rst_ovf", int'(overflow_A), 0);
    run(100, 1, 1'b0);
    expect_v("mid_rst_idle", pulses, 0);
    load_A = 1'b0; step();
    load_A = 1'b1; step();
    run(PA + 1, 1, 1'b1);
    expect_v("mid_rst_reload", pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
